control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter STEP_W, default 4, width of step counter (max step index 2^STEP_W-1, at least 8 steps required).
REQ-002 Parameter OPC_W, default 5, opcode width taken from IR_Data[31:27].
REQ-003 Parameter ALU_W, default 5, width of alu_instruction_bits.
REQ-004 clk  in  1  single system clock, rising-edge.
REQ-005 clr  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  level; high permits fetching of new instructions.
REQ-007 ir_opcode  in  OPC_W  opcode field of IR.
REQ-008 mem_rdy  in  1  memory read/write complete (used only under REQ-031).
REQ-009 Outputs, 1 bit each: PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out, IR_in, Grb, BAout, Y_in, C_out, Gra, Rin, Rout, Write.
REQ-010 alu_instruction_bits  out  ALU_W  ALU op select.
REQ-011 step  out  STEP_W  current T-step index; busy out 1; halted out 1; illegal out 1 (one-cycle pulse).

Function
REQ-012 States SHALL be IDLE, RUN (T0..Tn via step) and HALTED; all control outputs are a pure decode of state, step and latched opcode, and are 0 in IDLE and HALTED.
REQ-013 IDLE -> T0 on a clk edge with run=1; busy=1 whenever in RUN.
REQ-014 Fetch: T0 PC_out,MAR_in,IncPC,Z_in; T1 Zlow_out,PC_in,Read,MDR_in; T2 MDR_out,IR_in.
REQ-015 ir_opcode SHALL be latched on the clk edge leaving T2; T3 onward decode uses the latched value only.
REQ-016 ldi (00001): T3 Grb,BAout,Y_in; T4 C_out,Z_in,alu=00011; T5 Zlow_out,Gra,Rin; last step T5.
REQ-017 ld (00000): T3,T4 as ldi; T5 Zlow_out,MAR_in; T6 Read,MDR_in; T7 MDR_out,Gra,Rin.
REQ-018 st (00010): T3,T4 as ldi; T5 Zlow_out,MAR_in; T6 Gra,Rout,MDR_in; T7 Write.
REQ-019 addi/andi/ori (01100/01101/01110): T3 Grb,Rout,Y_in; T4 C_out,Z_in, alu=00011/00101/00110; T5 Zlow_out,Gra,Rin.
REQ-020 nop (11010): last step T2 effect only; sequencer leaves at T3 with no outputs asserted in T3.
REQ-021 halt (11011): transition T3 -> HALTED; halted=1 until reset; run ignored.
REQ-022 Any other opcode: illegal=1 for the T3 cycle, no datapath control asserted, then continue as nop.
REQ-023 After the last step: -> T0 if run=1, else -> IDLE; run dropping mid-instruction SHALL NOT truncate the instruction.
REQ-024 step SHALL never exceed the last step of the current instruction; no wrap-around beyond T7.
REQ-025 alu_instruction_bits SHALL be 0 outside T4.

Reset
REQ-026 clr=0 SHALL immediately force IDLE, step=0, latched opcode=0, all outputs 0, independent of clk.
REQ-027 Reset asserted mid-instruction SHALL abandon it; no partial Write or Rin after release.
REQ-028 First fetch after release requires a clk edge with clr=1 and run=1.

Configuration
REQ-029 Macro CSEQ_MEM_WAIT_EN selects memory handshaking.
REQ-030 Without CSEQ_MEM_WAIT_EN: every step lasts exactly one clk cycle; mem_rdy ignored.
REQ-031 With CSEQ_MEM_WAIT_EN: steps asserting Read or Write (T1, ld T6, st T7) SHALL hold, outputs stable, until mem_rdy=1 sampled at a clk edge; advance on that edge.

Structure
REQ-032 Shared package cseq_pkg SHALL hold opcode constants (OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_NOP, OPC_HALT), ALU code constants (ALU_ADD, ALU_AND, ALU_OR) and the state enum.
REQ-033 One sub-module, cseq_decode, SHALL be combinational: (state, step, opcode) -> control vector and last-step flag.

Verification
REQ-034 ir_opcode from IR 0x08800075 (ldi), run=1 -> steps 0..5, alu=00011 only in T4, Gra&Rin in T5, next cycle step=0.
REQ-035 st opcode with CSEQ_MEM_WAIT_EN, mem_rdy low 3 cycles in T7 -> Write held 4 cycles, then T0.
REQ-036 halt opcode -> halted=1 from the cycle after T3, all controls 0, persists with run=1 for 20 cycles.
REQ-037 clr pulsed low during ld T6 -> Read/MDR_in drop immediately, step=0, busy=0; restart fetch at T0.
REQ-038 opcode 11111 -> illegal=1 for one cycle, no Rin/Write, next instruction fetched.
REQ-039 run dropped during addi T4 -> T5 completes (Rin=1), then IDLE, busy=0.

Source files
------------

// File: rtl/cseq_pkg.sv
// Shared opcodes, ALU codes, state encoding and control vector for the control sequencer.
package cseq_pkg;

  localparam int unsigned OPC_BITS = 5;
  localparam int unsigned ALU_BITS = 5;

  localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_BITS-1:0] OPC_ANDI = 5'b01101;
  localparam logic [OPC_BITS-1:0] OPC_ORI  = 5'b01110;
  localparam logic [OPC_BITS-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_BITS-1:0] OPC_HALT = 5'b11011;

  localparam logic [ALU_BITS-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALU_BITS-1:0] ALU_AND = 5'b00101;
  localparam logic [ALU_BITS-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Datapath strobes plus sequencing flags (last step of instruction, halt request).
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic grb;
    logic ba_out;
    logic y_in;
    logic c_out;
    logic gra;
    logic rin;
    logic rout;
    logic write;
    logic illegal;
    logic last;
    logic halt;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle; master is the sequencer side.
interface control_sequencer_if #(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned ALU_W  = 5
);
  logic              run;
  logic [OPC_W-1:0]  ir_opcode;
  logic              mem_rdy;
  logic PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out;
  logic IR_in, Grb, BAout, Y_in, C_out, Gra, Rin, Rout, Write;
  logic [ALU_W-1:0]  alu_instruction_bits;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              halted;
  logic              illegal;

  modport master (
    input  run, ir_opcode, mem_rdy,
    output PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out,
           IR_in, Grb, BAout, Y_in, C_out, Gra, Rin, Rout, Write,
           alu_instruction_bits, step, busy, halted, illegal
  );

  modport slave (
    output run, ir_opcode, mem_rdy,
    input  PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out,
           IR_in, Grb, BAout, Y_in, C_out, Gra, Rin, Rout, Write,
           alu_instruction_bits, step, busy, halted, illegal
  );
endinterface

// File: rtl/cseq_decode.sv
// Combinational decode of (state, step, opcode) into the control vector and ALU select.
module cseq_decode
  import cseq_pkg::*;
#(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned ALU_W  = 5
) (
  input  state_e            state,
  input  logic [STEP_W-1:0] step,
  input  logic [OPC_W-1:0]  opc,
  output ctrl_t             ctl_c,
  output logic [ALU_W-1:0]  alu_c
);

  logic is_ld, is_ldi, is_st, is_addi, is_andi, is_ori, is_nop, is_halt, is_imm;

  always_comb begin
    is_ld   = (opc == OPC_W'(OPC_LD));
    is_ldi  = (opc == OPC_W'(OPC_LDI));
    is_st   = (opc == OPC_W'(OPC_ST));
    is_addi = (opc == OPC_W'(OPC_ADDI));
    is_andi = (opc == OPC_W'(OPC_ANDI));
    is_ori  = (opc == OPC_W'(OPC_ORI));
    is_nop  = (opc == OPC_W'(OPC_NOP));
    is_halt = (opc == OPC_W'(OPC_HALT));
    is_imm  = is_addi | is_andi | is_ori;
  end

  // Anything outside RUN decodes to all-zero controls.
  always_comb begin
    ctl_c = '0;
    alu_c = '0;
    if (state == ST_RUN) begin
      case (step)
        STEP_W'(0): begin
          ctl_c.pc_out = 1'b1; ctl_c.mar_in = 1'b1; ctl_c.inc_pc = 1'b1; ctl_c.z_in = 1'b1;
        end
        STEP_W'(1): begin
          ctl_c.zlow_out = 1'b1; ctl_c.pc_in = 1'b1; ctl_c.read = 1'b1; ctl_c.mdr_in = 1'b1;
        end
        STEP_W'(2): begin
          ctl_c.mdr_out = 1'b1; ctl_c.ir_in = 1'b1;
        end
        STEP_W'(3): begin
          if (is_ld || is_st || is_ldi) begin
            ctl_c.grb = 1'b1; ctl_c.ba_out = 1'b1; ctl_c.y_in = 1'b1;
          end else if (is_imm) begin
            ctl_c.grb = 1'b1; ctl_c.rout = 1'b1; ctl_c.y_in = 1'b1;
          end else if (is_halt) begin
            ctl_c.halt = 1'b1;
          end else begin
            ctl_c.last    = 1'b1;
            ctl_c.illegal = !is_nop;
          end
        end
        STEP_W'(4): begin
          ctl_c.c_out = 1'b1; ctl_c.z_in = 1'b1;
          alu_c = is_andi ? ALU_W'(ALU_AND) : (is_ori ? ALU_W'(ALU_OR) : ALU_W'(ALU_ADD));
        end
        STEP_W'(5): begin
          ctl_c.zlow_out = 1'b1;
          if (is_ld || is_st) begin
            ctl_c.mar_in = 1'b1;
          end else begin
            ctl_c.gra = 1'b1; ctl_c.rin = 1'b1; ctl_c.last = 1'b1;
          end
        end
        STEP_W'(6): begin
          ctl_c.mdr_in = 1'b1;
          ctl_c.read   = is_ld;
          ctl_c.gra    = is_st;
          ctl_c.rout   = is_st;
        end
        STEP_W'(7): begin
          ctl_c.mdr_out = is_ld;
          ctl_c.gra     = is_ld;
          ctl_c.rin     = is_ld;
          ctl_c.write   = is_st;
          ctl_c.last    = 1'b1;
        end
        // Unreachable steps terminate the instruction rather than wrap.
        default: ctl_c.last = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control sequencer. Optional memory handshaking: CSEQ_MEM_WAIT_EN.
module control_sequencer
  import cseq_pkg::*;
#(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned ALU_W  = 5
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master cs
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  ctrl_t             ctl_q, ctl_c;
  logic [ALU_W-1:0]  alu_q, alu_c;
  logic              busy_q, halted_q;
  logic              advance_c;

`ifdef CSEQ_MEM_WAIT_EN
  assign advance_c = !(ctl_q.read || ctl_q.write) || cs.mem_rdy;
`else
  logic unused_mem_rdy_c;
  assign unused_mem_rdy_c = cs.mem_rdy;
  assign advance_c = 1'b1;
`endif

  // Next state; the opcode is captured only when leaving T2.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    opc_d   = opc_q;
    case (state_q)
      ST_IDLE: begin
        if (cs.run) begin
          state_d = ST_RUN;
          step_d  = '0;
        end
      end
      ST_RUN: begin
        if (advance_c) begin
          if (ctl_q.halt) begin
            state_d = ST_HALTED;
            step_d  = '0;
          end else if (ctl_q.last) begin
            step_d = '0;
            if (!cs.run) state_d = ST_IDLE;
          end else begin
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(2)) opc_d = cs.ir_opcode;
          end
        end
      end
      default: ;
    endcase
  end

  // Decoding the next state lets the strobes come straight from flops.
  cseq_decode #(.STEP_W(STEP_W), .OPC_W(OPC_W), .ALU_W(ALU_W)) u_decode (
    .state (state_d),
    .step  (step_d),
    .opc   (opc_d),
    .ctl_c (ctl_c),
    .alu_c (alu_c)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      opc_q    <= '0;
      ctl_q    <= '0;
      alu_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      opc_q    <= opc_d;
      ctl_q    <= ctl_c;
      alu_q    <= alu_c;
      busy_q   <= (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign cs.PC_out   = ctl_q.pc_out;
  assign cs.MAR_in   = ctl_q.mar_in;
  assign cs.IncPC    = ctl_q.inc_pc;
  assign cs.Z_in     = ctl_q.z_in;
  assign cs.Zlow_out = ctl_q.zlow_out;
  assign cs.PC_in    = ctl_q.pc_in;
  assign cs.Read     = ctl_q.read;
  assign cs.MDR_in   = ctl_q.mdr_in;
  assign cs.MDR_out  = ctl_q.mdr_out;
  assign cs.IR_in    = ctl_q.ir_in;
  assign cs.Grb      = ctl_q.grb;
  assign cs.BAout    = ctl_q.ba_out;
  assign cs.Y_in     = ctl_q.y_in;
  assign cs.C_out    = ctl_q.c_out;
  assign cs.Gra      = ctl_q.gra;
  assign cs.Rin      = ctl_q.rin;
  assign cs.Rout     = ctl_q.rout;
  assign cs.Write    = ctl_q.write;
  assign cs.illegal  = ctl_q.illegal;
  assign cs.alu_instruction_bits = alu_q;
  assign cs.step     = step_q;
  assign cs.busy     = busy_q;
  assign cs.halted   = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random traffic against a step-table model.
module tb_control_sequencer;

  localparam int unsigned STEP_W = 4;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned ALU_W  = 5;
`ifdef CSEQ_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [17:0] M_PCO   = 18'h20000, M_MARIN = 18'h10000, M_INCPC = 18'h08000;
  localparam logic [17:0] M_ZIN   = 18'h04000, M_ZLOW  = 18'h02000, M_PCIN  = 18'h01000;
  localparam logic [17:0] M_READ  = 18'h00800, M_MDRIN = 18'h00400, M_MDROUT = 18'h00200;
  localparam logic [17:0] M_IRIN  = 18'h00100, M_GRB   = 18'h00080, M_BAOUT = 18'h00040;
  localparam logic [17:0] M_YIN   = 18'h00020, M_COUT  = 18'h00010, M_GRA   = 18'h00008;
  localparam logic [17:0] M_RIN   = 18'h00004, M_ROUT  = 18'h00002, M_WRITE = 18'h00001;

  typedef struct packed {
    logic [17:0] ctl;
    logic [4:0]  alu;
    logic        ill;
  } exp_t;

  logic clk;
  logic clr;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: per-instruction step table, mode 0 idle / 1 run / 2 halted.
  exp_t seq [8];
  int   seq_len;
  int   m_mode;
  int   m_idx;
  bit   m_halt;
  logic [31:0] ir_word;

  control_sequencer_if #(.STEP_W(STEP_W), .OPC_W(OPC_W), .ALU_W(ALU_W)) cs ();

  control_sequencer #(.STEP_W(STEP_W), .OPC_W(OPC_W), .ALU_W(ALU_W)) dut (
    .clk (clk),
    .clr (clr),
    .cs  (cs.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(logic [17:0] c, logic [4:0] a, logic i);
    exp_t e;
    e.ctl = c;
    e.alu = a;
    e.ill = i;
    return e;
  endfunction

  function automatic void load_exec(logic [4:0] opc);
    m_halt = 1'b0;
    for (int i = 3; i < 8; i++) seq[i] = '0;
    seq_len = 4;
    case (opc)
      5'b00001: begin
        seq[3] = mk(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
        seq[4] = mk(M_COUT | M_ZIN, 5'b00011, 1'b0);
        seq[5] = mk(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0);
        seq_len = 6;
      end
      5'b00000, 5'b00010: begin
        seq[3] = mk(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
        seq[4] = mk(M_COUT | M_ZIN, 5'b00011, 1'b0);
        seq[5] = mk(M_ZLOW | M_MARIN, 5'd0, 1'b0);
        if (opc == 5'b00000) begin
          seq[6] = mk(M_READ | M_MDRIN, 5'd0, 1'b0);
          seq[7] = mk(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
        end else begin
          seq[6] = mk(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
          seq[7] = mk(M_WRITE, 5'd0, 1'b0);
        end
        seq_len = 8;
      end
      5'b01100, 5'b01101, 5'b01110: begin
        seq[3] = mk(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
        seq[4] = mk(M_COUT | M_ZIN, (opc == 5'b01100) ? 5'b00011 :
                                    (opc == 5'b01101) ? 5'b00101 : 5'b00110, 1'b0);
        seq[5] = mk(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0);
        seq_len = 6;
      end
      5'b11010: ;
      5'b11011: m_halt = 1'b1;
      default:  seq[3] = mk(18'd0, 5'd0, 1'b1);
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void model_edge(logic r, logic [4:0] opc, logic rdy);
    case (m_mode)
      0: if (r) begin m_mode = 1; m_idx = 0; end
      1: begin
        if (WAIT_EN && ((seq[m_idx].ctl & (M_READ | M_WRITE)) != 18'd0) && !rdy) begin
          m_idx = m_idx;
        end else if (m_idx == 2) begin
          load_exec(opc);
          m_idx = 3;
        end else if (m_idx == seq_len - 1) begin
          if (m_halt) m_mode = 2;
          else if (r) m_idx = 0;
          else m_mode = 0;
        end else begin
          m_idx++;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [17:0] dut_ctl();
    return {cs.PC_out, cs.MAR_in, cs.IncPC, cs.Z_in, cs.Zlow_out, cs.PC_in, cs.Read,
            cs.MDR_in, cs.MDR_out, cs.IR_in, cs.Grb, cs.BAout, cs.Y_in, cs.C_out,
            cs.Gra, cs.Rin, cs.Rout, cs.Write};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(string tag);
    exp_t e;
    e = '0;
    if (m_mode == 1) e = seq[m_idx];
    chk({tag, ".ctl"},     32'(dut_ctl()), 32'(e.ctl));
    chk({tag, ".alu"},     32'(cs.alu_instruction_bits), 32'(e.alu));
    chk({tag, ".illegal"}, 32'(cs.illegal), 32'(e.ill));
    chk({tag, ".step"},    32'(cs.step), (m_mode == 1) ? 32'(m_idx) : 32'd0);
    chk({tag, ".busy"},    32'(cs.busy), 32'(m_mode == 1));
    chk({tag, ".halted"},  32'(cs.halted), 32'(m_mode == 2));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    #1;
    if (clr) model_edge(cs.run, cs.ir_opcode, cs.mem_rdy);
    check_outputs(tag);
  endtask

  task automatic advance_to(int k, string tag);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_idx == k) && n < 60) begin
      tick(tag);
      n++;
    end
    chk({tag, ".reached"}, 32'(cs.step), 32'(k));
  endtask

  task automatic run_until_idle(string tag);
    int n;
    n = 0;
    while (m_mode != 0 && n < 60) begin
      tick(tag);
      n++;
    end
    chk({tag, ".idle"}, 32'(cs.busy), 32'd0);
  endtask

  function automatic logic [4:0] pick_opc();
    logic [4:0] r;
    case ($urandom_range(0, 7))
      0: r = 5'b00000;
      1: r = 5'b00001;
      2: r = 5'b00010;
      3: r = 5'b01100;
      4: r = 5'b01101;
      5: r = 5'b01110;
      6: r = 5'b11010;
      default: begin
        r = 5'($urandom_range(0, 31));
        if (r == 5'b11011) r = 5'b11111;
      end
    endcase
    return r;
  endfunction

  initial begin
    seq[0] = mk(M_PCO | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b0);
    seq[1] = mk(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b0);
    seq[2] = mk(M_MDROUT | M_IRIN, 5'd0, 1'b0);
    for (int i = 3; i < 8; i++) seq[i] = '0;
    seq_len = 3;
    m_mode = 0; m_idx = 0; m_halt = 1'b0;
    cs.run = 1'b1; cs.ir_opcode = 5'b00000; cs.mem_rdy = 1'b1;

    // Reset before any clock edge.
    clr = 1'b1;
    #1 clr = 1'b0;
    #2 check_outputs("reset_async");
    tick("reset_hold");
    tick("reset_hold");
    @(negedge clk);
    clr = 1'b1;
    cs.run = 1'b0;
    tick("idle_no_run");

    // ldi taken from a full instruction word.
    ir_word = 32'h08800075;
    cs.ir_opcode = ir_word[31:27];
    cs.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("ldi");
      chk("ldi_step", 32'(cs.step), 32'(i));
      if (i == 4) chk("ldi_alu_t4", 32'(cs.alu_instruction_bits), 32'h3);
      if (i == 5) chk("ldi_gra_rin_t5", 32'({cs.Gra, cs.Rin}), 32'h3);
    end
    tick("ldi_next");
    chk("ldi_next_step0", 32'(cs.step), 32'd0);
    cs.run = 1'b0;
    run_until_idle("ldi_drain");

    // run drops during addi T4; instruction still completes.
    cs.run = 1'b1;
    cs.ir_opcode = 5'b01100;
    for (int i = 0; i < 5; i++) tick("addi");
    cs.run = 1'b0;
    tick("addi_t5");
    chk("addi_t5_rin", 32'(cs.Rin), 32'd1);
    tick("addi_done");
    chk("addi_idle_busy", 32'(cs.busy), 32'd0);

    // Illegal opcode pulses illegal once, then fetch continues.
    cs.run = 1'b1;
    cs.ir_opcode = 5'b11111;
    for (int i = 0; i < 4; i++) tick("illegal");
    chk("illegal_t3", 32'(cs.illegal), 32'd1);
    chk("illegal_no_rin_write", 32'({cs.Rin, cs.Write}), 32'd0);
    cs.ir_opcode = 5'b00001;
    tick("illegal_next");
    chk("illegal_next_t0", 32'({cs.illegal, cs.PC_out, cs.busy}), 32'h3);
    cs.run = 1'b0;
    run_until_idle("illegal_drain");

    // Async reset during ld T6 abandons the instruction.
    cs.run = 1'b1;
    cs.ir_opcode = 5'b00000;
    cs.mem_rdy = 1'b1;
    advance_to(6, "ld_to_t6");
    chk("ld_t6_read", 32'({cs.Read, cs.MDR_in}), 32'h3);
    #2 clr = 1'b0;
    #1;
    m_mode = 0;
    chk("rst_mid_read_mdr", 32'({cs.Read, cs.MDR_in}), 32'd0);
    chk("rst_mid_step", 32'(cs.step), 32'd0);
    chk("rst_mid_busy", 32'(cs.busy), 32'd0);
    check_outputs("rst_mid");
    cs.ir_opcode = 5'b11010;
    tick("rst_mid_hold");
    @(negedge clk);
    clr = 1'b1;
    tick("restart");
    chk("restart_t0", 32'({cs.PC_out, cs.busy}), 32'h3);
    cs.run = 1'b0;
    run_until_idle("restart_drain");

`ifdef CSEQ_MEM_WAIT_EN
    // st T7 held by mem_rdy low for three edges.
    cs.run = 1'b1;
    cs.ir_opcode = 5'b00010;
    cs.mem_rdy = 1'b1;
    advance_to(7, "st_to_t7");
    chk("st_write_1", 32'(cs.Write), 32'd1);
    cs.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("st_wait");
      chk("st_write_held", 32'(cs.Write), 32'd1);
    end
    cs.mem_rdy = 1'b1;
    tick("st_release");
    chk("st_release_t0", 32'({cs.Write, cs.PC_out}), 32'h1);
    cs.run = 1'b0;
    run_until_idle("st_drain");
`endif

    // Random traffic; the opcode input changes every cycle.
    for (int c = 0; c < 400; c++) begin
      cs.run = ($urandom_range(0, 7) != 0);
      cs.ir_opcode = pick_opc();
      cs.mem_rdy = ($urandom_range(0, 1) != 0);
      tick("rand");
    end
    cs.run = 1'b0;
    cs.mem_rdy = 1'b1;
    run_until_idle("rand_drain");

    // halt is sticky regardless of run.
    cs.run = 1'b1;
    cs.ir_opcode = 5'b11011;
    advance_to(3, "halt_to_t3");
    tick("halt_enter");
    chk("halt_halted", 32'(cs.halted), 32'd1);
    chk("halt_ctl_zero", 32'(dut_ctl()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick("halt_hold");
      chk("halt_persist", 32'({cs.halted, cs.busy}), 32'h2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
